// File: rtl/coin_input_cond.sv
// Player input conditioner: per-bit debounce of 8 buttons plus coin, and coin shaping into queued, frame-timed pulses.
// Latency: debounce DB_LEN ce samples + 1 clk; coin_out rises 1 clk after IDLE sees a credit. No backpressure: a press into a full queue is dropped and flagged on coin_ovf.
module coin_input_cond #(
   parameter int unsigned DB_LEN   = 4,
   parameter int unsigned COIN_ON  = 8,
   parameter int unsigned COIN_OFF = 8,
   parameter int unsigned QMAX     = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       vblank,
   input  logic [7:0] btn_in,
   input  logic       coin_in,
   output logic [7:0] btn_out,
   output logic       coin_out,
   output logic [2:0] coin_q,
   output logic       coin_ovf
);

   localparam int          NB       = 9;
   localparam logic [3:0]  DB_LAST  = 4'(DB_LEN - 1);
   localparam logic [7:0]  ON_LAST  = 8'(COIN_ON - 1);
   localparam logic [7:0]  OFF_LAST = 8'(COIN_OFF - 1);
   localparam logic [2:0]  QCAP     = 3'(QMAX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   logic [NB-1:0] raw;
   logic [NB-1:0] stable;
   logic [3:0]    db_cnt [NB];

   logic          coin_db_d;
   logic          coin_req;
   logic          vblank_d;
   logic          ftick;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    fcnt;
   logic [7:0]    fcnt_nxt;
   logic          deq;
   logic          accept;
   logic          ovf;
   logic [2:0]    coin_q_nxt;

   // bit 8 carries the coin line through the same debouncer as the buttons
   assign raw = {coin_in, btn_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
         for (int i = 0; i < NB; i++) begin
            db_cnt[i] <= '0;
         end
      end else if (ce) begin
         for (int i = 0; i < NB; i++) begin
            if (raw[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= raw[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_out   <= '0;
         coin_db_d <= 1'b0;
         vblank_d  <= 1'b0;
      end else begin
         btn_out   <= stable[7:0];
         coin_db_d <= stable[8];
         vblank_d  <= vblank;
      end
   end

   assign coin_req = stable[8] & ~coin_db_d;
   assign ftick    = vblank & ~vblank_d;

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      deq       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (coin_q != 3'd0) begin
               deq       = 1'b1;
               state_nxt = ST_ON;
               fcnt_nxt  = 8'd0;
            end
         end
         ST_ON: begin
            if (ftick) begin
               if (fcnt == ON_LAST) begin
                  state_nxt = ST_OFF;
                  fcnt_nxt  = 8'd0;
               end else begin
                  fcnt_nxt = fcnt + 8'd1;
               end
            end
         end
         ST_OFF: begin
            if (ftick) begin
               if (fcnt == OFF_LAST) begin
                  state_nxt = ST_IDLE;
                  fcnt_nxt  = 8'd0;
               end else begin
                  fcnt_nxt = fcnt + 8'd1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            fcnt_nxt  = 8'd0;
         end
      endcase
   end

   // a dequeue in the same clk frees a slot, so a full queue still takes the press
   always_comb begin
      accept     = coin_req & ((coin_q < QCAP) | deq);
      ovf        = coin_req & ~accept;
      coin_q_nxt = coin_q + {2'b00, accept} - {2'b00, deq};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         fcnt     <= 8'd0;
         coin_q   <= 3'd0;
         coin_out <= 1'b0;
         coin_ovf <= 1'b0;
      end else begin
         state    <= state_nxt;
         fcnt     <= fcnt_nxt;
         coin_q   <= coin_q_nxt;
         coin_out <= (state_nxt == ST_ON);
         coin_ovf <= ovf;
      end
   end

endmodule

// File: tb/tb_coin_input_cond.sv
// Bench for coin_input_cond: sliding-window debounce model checked every clk, coin pulses measured in frames.
module tb_coin_input_cond;

   localparam int DB_LEN   = 4;
   localparam int COIN_ON  = 8;
   localparam int COIN_OFF = 8;
   localparam int QMAX     = 7;
   localparam int CE_DIV   = 4;
   localparam int VB_PER   = 100;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b0;
   logic       vblank = 1'b0;
   logic [7:0] btn_in = 8'h00;
   logic       coin_in = 1'b0;
   logic [7:0] btn_out;
   logic       coin_out;
   logic [2:0] coin_q;
   logic       coin_ovf;

   always #5 clk = ~clk;

   coin_input_cond #(
      .DB_LEN(DB_LEN), .COIN_ON(COIN_ON), .COIN_OFF(COIN_OFF), .QMAX(QMAX)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .vblank(vblank),
      .btn_in(btn_in), .coin_in(coin_in),
      .btn_out(btn_out), .coin_out(coin_out), .coin_q(coin_q), .coin_ovf(coin_ovf)
   );

   int checks = 0;
   int errors = 0;

   int edge_cnt = 0;
   bit ce_en = 1'b0;
   bit vb_run = 1'b0;
   int vb_phase = 0;
   bit vb_last = 1'b0;

   logic [7:0] hist[$];
   logic [7:0] mdl_stable = 8'h00;
   logic [7:0] mdl_out = 8'h00;

   int   pulses = 0;
   int   ovf_cnt = 0;
   int   peak_q = 0;
   int   q_at_rise = 0;
   int   on_ft = 0;
   int   off_ft = 0;
   bit   have_fall = 1'b0;
   logic co_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clk: capture what the DUT samples, advance, update the models, re-drive ce/vblank.
   task automatic tick();
      logic       ce_s;
      logic       vb_s;
      logic [7:0] btn_s;
      logic [7:0] h;
      bit         ft_l;
      bit         all_diff;
      ce_s  = ce;
      vb_s  = vblank;
      btn_s = btn_in;
      @(posedge clk);
      #1;
      edge_cnt++;
      if (!reset_n) begin
         hist.delete();
         mdl_stable = 8'h00;
         mdl_out    = 8'h00;
         vb_last    = 1'b0;
         co_prev    = 1'b0;
         have_fall  = 1'b0;
         on_ft      = 0;
         off_ft     = 0;
      end else begin
         // a bit flips once its last DB_LEN ce samples all disagree with it
         mdl_out = mdl_stable;
         if (ce_s) begin
            hist.push_back(btn_s);
            if (hist.size() > DB_LEN) void'(hist.pop_front());
            if (hist.size() == DB_LEN) begin
               for (int b = 0; b < 8; b++) begin
                  all_diff = 1'b1;
                  for (int i = 0; i < DB_LEN; i++) begin
                     h = hist[i];
                     if (h[b] == mdl_stable[b]) all_diff = 1'b0;
                  end
                  if (all_diff) mdl_stable[b] = ~mdl_stable[b];
               end
            end
         end
         chk("btn_out", {24'd0, btn_out}, {24'd0, mdl_out});

         ft_l    = vb_s && !vb_last;
         vb_last = vb_s;
         if (coin_ovf) ovf_cnt++;
         if (int'(coin_q) > peak_q) peak_q = int'(coin_q);
         if (ft_l && co_prev) on_ft++;
         if (ft_l && !co_prev) off_ft++;
         if (!co_prev && coin_out) begin
            pulses++;
            q_at_rise = int'(coin_q);
            if (have_fall) chk("off_gap_frames", {31'd0, off_ft >= COIN_OFF}, 32'd1);
            on_ft = 0;
         end
         if (co_prev && !coin_out) begin
            chk("on_frames", on_ft, COIN_ON);
            chk("fall_on_ftick", {31'd0, ft_l}, 32'd1);
            off_ft    = 0;
            have_fall = 1'b1;
         end
         co_prev = coin_out;
      end
      ce = ce_en && (((edge_cnt + 1) % CE_DIV) == 0);
      if (vb_run) begin
         vb_phase = (vb_phase + 1) % VB_PER;
         vblank   = (vb_phase < 10);
      end
   endtask

   task automatic press();
      coin_in = 1'b1;
      repeat (24) tick();
      coin_in = 1'b0;
      repeat (24) tick();
   endtask

   task automatic align_ce();
      while ((edge_cnt % CE_DIV) != 0) tick();
   endtask

   task automatic drain(input int target);
      int n;
      n = 0;
      while ((pulses < target || coin_out || off_ft < COIN_OFF) && n < 20000) begin
         tick();
         n++;
      end
      chk("drain_in_time", {31'd0, n < 20000}, 32'd1);
      repeat (5) tick();
   endtask

   // Presses land inside the first ON period: one starts at once, QMAX wait, rest drop.
   task automatic run_presses(input int n, input string tag);
      int base;
      int ovf0;
      int exp_p;
      int exp_peak;
      base     = pulses;
      ovf0     = ovf_cnt;
      peak_q   = 0;
      exp_p    = (n < QMAX + 1) ? n : QMAX + 1;
      exp_peak = (n - 1 > QMAX) ? QMAX : ((n - 1 < 1) ? 1 : n - 1);
      repeat (n) press();
      drain(base + exp_p);
      chk({tag, "_pulses"}, pulses - base, exp_p);
      chk({tag, "_ovf"}, ovf_cnt - ovf0, n - exp_p);
      chk({tag, "_peak_q"}, peak_q, exp_peak);
      chk({tag, "_q_empty"}, {29'd0, coin_q}, 32'd0);
   endtask

   initial begin
      int n;
      int base;
      int ovf0;

      reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_btn_out", {24'd0, btn_out}, 32'd0);
      chk("rst_coin_out", {31'd0, coin_out}, 32'd0);
      chk("rst_coin_q", {29'd0, coin_q}, 32'd0);
      chk("rst_coin_ovf", {31'd0, coin_ovf}, 32'd0);
      reset_n = 1'b1;

      // no ce: nothing may be debounced or queued
      repeat (30) begin
         btn_in  = 8'($urandom);
         coin_in = 1'($urandom);
         tick();
      end
      chk("noce_btn_out", {24'd0, btn_out}, 32'd0);
      chk("noce_coin_q", {29'd0, coin_q}, 32'd0);
      chk("noce_coin_out", {31'd0, coin_out}, 32'd0);
      btn_in  = 8'h00;
      coin_in = 1'b0;
      ce_en   = 1'b1;
      vb_run  = 1'b1;
      repeat (20) tick();

      align_ce();
      btn_in[2] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!btn_out[2] && n < 40);
      chk("db_latency_clk", n, DB_LEN * CE_DIV + 1);

      align_ce();
      btn_in[5] = 1'b1;
      repeat (3 * CE_DIV) tick();
      btn_in[5] = 1'b0;
      repeat (40) tick();
      chk("glitch_btn5", {31'd0, btn_out[5]}, 32'd0);

      repeat (40) begin
         btn_in = 8'($urandom);
         repeat ($urandom_range(1, 24)) tick();
      end
      btn_in = 8'h00;
      repeat (40) tick();
      chk("btn_settle_zero", {24'd0, btn_out}, 32'd0);

      run_presses(1, "single");
      chk("single_q_at_rise", q_at_rise, 0);
      run_presses(3, "triple");
      run_presses(int'($urandom_range(1, 9)), "rand");

      // nine presses, then a press timed onto the IDLE dequeue with a full queue
      base   = pulses;
      ovf0   = ovf_cnt;
      peak_q = 0;
      repeat (9) press();
      chk("mash_peak_q", peak_q, QMAX);
      chk("mash_ovf", ovf_cnt - ovf0, 9 - (QMAX + 1));
      chk("mash_q_full", {29'd0, coin_q}, QMAX);

      n = 0;
      while (!(pulses == base + 1 && off_ft == COIN_OFF - 1) && n < 20000) begin
         tick();
         n++;
      end
      chk("reach_last_off_frame", {31'd0, n < 20000}, 32'd1);
      vb_run = 1'b0;
      vblank = 1'b0;
      align_ce();
      coin_in = 1'b1;
      repeat (DB_LEN * CE_DIV - 1) tick();
      vblank = 1'b1;
      tick();
      tick();
      chk("simul_coin_q", {29'd0, coin_q}, QMAX);
      chk("simul_coin_out", {31'd0, coin_out}, 32'd1);
      chk("simul_ovf", {31'd0, coin_ovf}, 32'd0);
      tick();
      chk("simul_ovf_next", {31'd0, coin_ovf}, 32'd0);
      chk("simul_coin_q_next", {29'd0, coin_q}, QMAX);
      repeat (8) tick();
      vblank  = 1'b0;
      coin_in = 1'b0;
      repeat (24) tick();
      vb_phase = 20;
      vb_run   = 1'b1;
      chk("simul_ovf_total", ovf_cnt - ovf0, 9 - (QMAX + 1));

      n = 0;
      while (!(coin_out && coin_q == 3'd3) && n < 20000) begin
         tick();
         n++;
      end
      chk("reach_q3_on", {31'd0, n < 20000}, 32'd1);
      chk("pulses_at_q3", pulses - base, 2 + (QMAX - 3));

      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_coin_out", {31'd0, coin_out}, 32'd0);
      chk("midrst_coin_q", {29'd0, coin_q}, 32'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      base = pulses;
      repeat (2500) tick();
      chk("post_rst_no_pulse", pulses - base, 0);
      chk("post_rst_q", {29'd0, coin_q}, 32'd0);

      press();
      n = 0;
      while (pulses == base && n < 2000) begin
         tick();
         n++;
      end
      chk("post_rst_new_pulse", pulses - base, 1);
      chk("post_rst_q_at_rise", q_at_rise, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
